// File: rtl/circle_sprite_reader.sv
// circle_sprite_reader
// Per-scanline reader for the 64x64 circle bitmap ROM. During hblank it
// fetches the ROM row that intersects the next line into a line buffer.
// During active video it turns the pixel counters into a registered
// pixel_on / rgb pair. The sprite position is latched once per frame.
//
// Build option: define CIRCLE_SCALE2X_EN to draw the sprite 128x128. Each
// ROM row then covers two lines and each bit covers two pixels.
//
// Handshake: there is none. line_start and frame_start are single-cycle
// strobes, and rom_data is sampled in LOAD, one cycle after rom_addr settles.
module circle_sprite_reader #(
   parameter int          H_ACTIVE = 640,
   parameter int          V_ACTIVE = 480,
   parameter logic [11:0] COLOR    = 12'hF00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_start,
   input  logic [9:0]  pos_x,
   input  logic [9:0]  pos_y,
   input  logic        line_start,
   input  logic [9:0]  next_line,
   input  logic [9:0]  hcount,
   input  logic        video_on,
   output logic [5:0]  rom_addr,
   input  logic [63:0] rom_data,
   output logic        pixel_on,
   output logic [11:0] rgb,
   output logic        busy
);

`ifdef CIRCLE_SCALE2X_EN
   localparam logic [10:0] SPAN = 11'd128;
`else
   localparam logic [10:0] SPAN = 11'd64;
`endif
   localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
   localparam logic [9:0] V_LAST = 10'(V_ACTIVE - 1);

   typedef enum logic [1:0] {IDLE, ADDR, LOAD} state_t;

   state_t      state;
   logic [9:0]  px_l;
   logic [9:0]  py_l;
   logic [9:0]  py_eff;
   logic        line_valid;
   logic [63:0] line_buf;
   logic [10:0] dy;
   logic [10:0] dx;
   logic        row_in;
   logic        col_in;
   logic [5:0]  row_sel;
   logic [5:0]  bit_sel;
   logic        hit;

   // Row/column offsets and the pixel hit decision. The latch is bypassed
   // into dy so a frame_start coinciding with line_start uses the new pos_y.
   always_comb begin
      py_eff = frame_start ? pos_y : py_l;
      dy     = {1'b0, next_line} - {1'b0, py_eff};
      dx     = {1'b0, hcount} - {1'b0, px_l};
      // The screen-limit terms never trigger for legal counters; they only
      // make clipping explicit at the right and bottom edges.
      row_in = ~dy[10] && (dy < SPAN) && (next_line <= V_LAST);
      col_in = ~dx[10] && (dx < SPAN) && (hcount <= H_LAST);
`ifdef CIRCLE_SCALE2X_EN
      row_sel = dy[6:1];
      bit_sel = 6'd63 - dx[6:1];
`else
      row_sel = dy[5:0];
      bit_sel = 6'd63 - dx[5:0];
`endif
      hit = video_on & line_valid & col_in & line_buf[bit_sel];
   end

   // Sprite position is sampled once per frame so the circle never tears.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         px_l <= '0;
         py_l <= '0;
      end else if (frame_start) begin
         px_l <= pos_x;
         py_l <= pos_y;
      end
   end

   // Fetch FSM: IDLE -> ADDR (address settles) -> LOAD (capture row) -> IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         rom_addr   <= '0;
         busy       <= 1'b0;
         line_valid <= 1'b0;
         line_buf   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (line_start) begin
                  if (row_in) begin
                     rom_addr <= row_sel;
                     busy     <= 1'b1;
                     state    <= ADDR;
                  end else begin
                     line_valid <= 1'b0;
                  end
               end
            end
            ADDR: begin
               state <= LOAD;
            end
            LOAD: begin
               line_buf   <= rom_data;
               line_valid <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Registered pixel outputs, one cycle behind hcount/video_on.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pixel_on <= 1'b0;
         rgb      <= '0;
      end else begin
         pixel_on <= hit;
         rgb      <= hit ? COLOR : 12'h000;
      end
   end

endmodule

// File: tb/tb_circle_sprite_reader.sv
// Testbench for circle_sprite_reader: table of directed probes, hand-written
// multi-cycle sequences, and randomized lines against a geometric model.
module tb_circle_sprite_reader;

`ifdef CIRCLE_SCALE2X_EN
   localparam int S = 2;
`else
   localparam int S = 1;
`endif
   localparam logic [11:0] RED = 12'hF00;

   logic        clk;
   logic        rst_n;
   logic        frame_start;
   logic [9:0]  pos_x;
   logic [9:0]  pos_y;
   logic        line_start;
   logic [9:0]  next_line;
   logic [9:0]  hcount;
   logic        video_on;
   logic [5:0]  rom_addr;
   logic [63:0] rom_data;
   logic        pixel_on;
   logic [11:0] rgb;
   logic        busy;

   logic [63:0] rom [64];
   logic [12:0] exp_q [$];
   int          checks;
   int          failures;

   typedef struct {
      int   px;
      int   py;
      int   nl;
      int   hc;
      logic exp_on;
   } vec_t;

   vec_t vt [12];

   assign rom_data = rom[rom_addr];

   circle_sprite_reader dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .pos_x       (pos_x),
      .pos_y       (pos_y),
      .line_start  (line_start),
      .next_line   (next_line),
      .hcount      (hcount),
      .video_on    (video_on),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .pixel_on    (pixel_on),
      .rgb         (rgb),
      .busy        (busy)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Geometric reference: sprite pixel from screen position and ROM image.
   function automatic logic model_pixel(input int px, input int py, input int nl,
                                        input int h, input logic von);
      int row;
      int col;
      row = nl - py;
      col = h - px;
      if (!von || row < 0 || row >= 64 * S || col < 0 || col >= 64 * S)
         return 1'b0;
      return rom[row / S][63 - col / S];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Latch a new sprite position with a frame_start pulse.
   task automatic latch_pos(input int px, input int py);
      @(negedge clk);
      frame_start = 1'b1;
      pos_x       = 10'(px);
      pos_y       = 10'(py);
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   // Launch a line fetch and check busy / rom_addr timing.
   task automatic fetch_line(input int nl, input int py);
      int   row;
      logic in_range;
      row      = nl - py;
      in_range = (row >= 0 && row < 64 * S);
      line_start = 1'b1;
      next_line  = 10'(nl);
      @(negedge clk);
      line_start = 1'b0;
      check("busy_t1", 64'(busy), 64'(in_range));
      if (in_range) check("rom_addr", 64'(rom_addr), 64'(row / S));
      @(negedge clk);
      check("busy_t2", 64'(busy), 64'(in_range));
      @(negedge clk);
      check("busy_done", 64'(busy), 64'(0));
   endtask

   // Present one pixel and check the registered outputs a cycle later.
   task automatic probe(input string name, input int h, input logic von, input logic exp);
      hcount   = 10'(h);
      video_on = von;
      @(negedge clk);
      check({name, "_pixel_on"}, 64'(pixel_on), 64'(exp));
      check({name, "_rgb"}, 64'(rgb), 64'(exp ? RED : 12'h000));
      video_on = 1'b0;
   endtask

   initial begin
      int px;
      int py;
      int nl;
      int lo;
      int hi;
      int h;
      logic von;
      logic p;
      logic [12:0] got;

      checks   = 0;
      failures = 0;

      // ROM image: row 0 spans columns 26..37, row 26 is full width.
      for (int r = 0; r < 64; r++) rom[r] = {$urandom, $urandom};
      rom[0]  = 64'h0;
      for (int c = 26; c <= 37; c++) rom[0][63 - c] = 1'b1;
      rom[26] = {64{1'b1}};

`ifdef CIRCLE_SCALE2X_EN
      vt[0]  = '{0,   0,  53, 0,   1'b1};
      vt[1]  = '{0,   0,  53, 127, 1'b1};
      vt[2]  = '{0,   0,  53, 128, 1'b0};
      vt[3]  = '{100, 50, 50, 151, 1'b0};
      vt[4]  = '{100, 50, 50, 152, 1'b1};
      vt[5]  = '{100, 50, 51, 175, 1'b1};
      vt[6]  = '{100, 50, 51, 176, 1'b0};
      vt[7]  = '{100, 50, 49, 160, 1'b0};
      vt[8]  = '{100, 50, 178, 160, 1'b0};
      vt[9]  = '{600, 0,  53, 600, 1'b1};
      vt[10] = '{600, 0,  53, 639, 1'b1};
      vt[11] = '{600, 0,  53, 23,  1'b0};
`else
      vt[0]  = '{100, 50, 50,  125, 1'b0};
      vt[1]  = '{100, 50, 50,  126, 1'b1};
      vt[2]  = '{100, 50, 50,  137, 1'b1};
      vt[3]  = '{100, 50, 50,  138, 1'b0};
      vt[4]  = '{100, 50, 76,  99,  1'b0};
      vt[5]  = '{100, 50, 76,  100, 1'b1};
      vt[6]  = '{100, 50, 76,  163, 1'b1};
      vt[7]  = '{100, 50, 76,  164, 1'b0};
      vt[8]  = '{100, 50, 49,  130, 1'b0};
      vt[9]  = '{100, 50, 114, 130, 1'b0};
      vt[10] = '{600, 50, 76,  639, 1'b1};
      vt[11] = '{600, 50, 76,  23,  1'b0};
`endif

      // Reset
      rst_n = 1'b0; frame_start = 1'b0; pos_x = '0; pos_y = '0;
      line_start = 1'b0; next_line = '0; hcount = '0; video_on = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_rom_addr", 64'(rom_addr), 64'(0));
      check("reset_pixel_on", 64'(pixel_on), 64'(0));
      check("reset_rgb", 64'(rgb), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 12; i++) begin
         latch_pos(vt[i].px, vt[i].py);
         fetch_line(vt[i].nl, vt[i].py);
         probe("table", vt[i].hc, 1'b1, vt[i].exp_on);
      end

      // Full sweep of the row-0 line against the model
      latch_pos(100, 50);
      fetch_line(50, 50);
      for (int x = 90; x < 240; x++) probe("sweep", x, 1'b1, model_pixel(100, 50, 50, x, 1'b1));

      // Position change without frame_start has no effect until latched
      latch_pos(100, 50);
      pos_x = 10'd300;
      @(negedge clk);
      fetch_line(76, 50);
      probe("latch_hold", 100, 1'b1, model_pixel(100, 50, 76, 100, 1'b1));
      latch_pos(300, 50);
      fetch_line(76, 50);
      probe("latch_new_old", 100, 1'b1, model_pixel(300, 50, 76, 100, 1'b1));
      probe("latch_new", 300, 1'b1, model_pixel(300, 50, 76, 300, 1'b1));

      // frame_start coinciding with line_start uses the new pos_y
      latch_pos(100, 50);
      @(negedge clk);
      frame_start = 1'b1; pos_x = 10'd100; pos_y = 10'd70;
      line_start  = 1'b1; next_line = 10'd70;
      @(negedge clk);
      frame_start = 1'b0; line_start = 1'b0;
      check("bypass_rom_addr", 64'(rom_addr), 64'(0));
      check("bypass_busy", 64'(busy), 64'(1));
      repeat (2) @(negedge clk);
      probe("bypass", 126, 1'b1, model_pixel(100, 70, 70, 126, 1'b1));

      // line_start during a fetch is ignored
      latch_pos(100, 50);
      line_start = 1'b1; next_line = 10'd76;
      @(negedge clk);
      next_line = 10'd50;
      check("ignore_addr_t1", 64'(rom_addr), 64'(26 / S));
      @(negedge clk);
      line_start = 1'b0;
      check("ignore_busy_t2", 64'(busy), 64'(1));
      check("ignore_addr_t2", 64'(rom_addr), 64'(26 / S));
      @(negedge clk);
      check("ignore_busy_t3", 64'(busy), 64'(0));
      @(negedge clk);
      check("ignore_no_refetch", 64'(busy), 64'(0));
      probe("ignore", 100, 1'b1, model_pixel(100, 50, 76, 100, 1'b1));

      // Reset asserted one cycle into a fetch blanks the line
      latch_pos(100, 50);
      fetch_line(76, 50);
      line_start = 1'b1; next_line = 10'd76;
      @(negedge clk);
      line_start = 1'b0;
      check("rst_mid_busy_before", 64'(busy), 64'(1));
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_mid_busy", 64'(busy), 64'(0));
      for (int x = 0; x < 640; x += 4) probe("rst_blank", x, 1'b1, 1'b0);
      check("rst_blank_busy", 64'(busy), 64'(0));

      // Randomized lines: scoreboard of expected {pixel_on, rgb}
      for (int f = 0; f < 80; f++) begin
         px = $urandom_range(0, 639);
         py = $urandom_range(0, 479);
         lo = (py > 10) ? py - 10 : 0;
         hi = (py + 140 > 479) ? 479 : py + 140;
         nl = $urandom_range(lo, hi);
         latch_pos(px, py);
         fetch_line(nl, py);
         for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 3) != 0) begin
               lo = (px > 4) ? px - 4 : 0;
               hi = (px + 64 * S + 4 > 639) ? 639 : px + 64 * S + 4;
               h  = $urandom_range(lo, hi);
            end else begin
               h = $urandom_range(0, 639);
            end
            von = ($urandom_range(0, 7) != 0);
            p   = model_pixel(px, py, nl, h, von);
            exp_q.push_back({p, p ? RED : 12'h000});
            hcount   = 10'(h);
            video_on = von;
            @(negedge clk);
            got = {pixel_on, rgb};
            check("random_pixel", 64'(got), 64'(exp_q.pop_front()));
         end
         video_on = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
